// File: rtl/spill_slot_scheduler.sv
// rtl/spill_slot_scheduler.sv - round-robin spill-slot allocator over a circular pool
// Regions are granted one per cycle and reclaimed strictly in allocation order.
module spill_slot_scheduler #(
    parameter int NREQ   = 8,
    parameter int SLOTS  = 256,
    parameter int ADDR_W = $clog2(SLOTS),
    parameter int IDW    = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_n,
    input  logic [NREQ-1:0]   rel_valid,
    output logic              gnt_valid,
    output logic [IDW-1:0]    gnt_id,
    output logic [ADDR_W-1:0] gnt_base,
    output logic [7:0]        gnt_n,
    output logic [NREQ-1:0]   owned,
    output logic [ADDR_W:0]   used_slots,
    output logic              rec_valid,
    output logic [ADDR_W-1:0] rec_base,
    output logic [7:0]        rec_n,
    output logic              err
);

    logic [ADDR_W-1:0] head, tail;
    logic [ADDR_W:0]   used;
    logic [IDW-1:0]    rr;

    // Order FIFO; the base field is implied by tail since pops follow allocation order.
    logic [IDW-1:0]    f_id    [NREQ];
    logic [7:0]        f_n     [NREQ];
    logic [NREQ-1:0]   f_done;
    logic [IDW-1:0]    slot_of [NREQ];
    logic [IDW-1:0]    wr_ptr, rd_ptr;
    logic [IDW:0]      count;

    logic [NREQ-1:0]   legal, elig, rel_ok, owned_next;
    logic              found, grant, pop, err_set;
    logic [IDW-1:0]    cand, idx;
    logic [7:0]        cand_n;
    logic [ADDR_W:0]   free_slots, gadd, radd;

    always_comb begin
        legal  = '0;
        elig   = '0;
        rel_ok = '0;
        for (int i = 0; i < NREQ; i++) begin
            legal[i]  = (req_n[8*i +: 8] != 8'd0) && (int'(req_n[8*i +: 8]) <= SLOTS);
            elig[i]   = req_valid[i] && !owned[i] && legal[i];
            rel_ok[i] = owned[i] && !f_done[slot_of[i]];
        end
    end

    // Only the first eligible requester from rr is considered: no skipping past a misfit.
    always_comb begin
        found = 1'b0;
        cand  = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = rr + IDW'(k);
            if (!found && elig[idx]) begin
                found = 1'b1;
                cand  = idx;
            end
        end
    end

    always_comb begin
        cand_n     = req_n[{cand, 3'b000} +: 8];
        free_slots = (ADDR_W+1)'(SLOTS) - used;
        grant      = found && (int'(cand_n) <= int'(free_slots));
        pop        = (count != '0) && f_done[rd_ptr];
        gadd       = grant ? (ADDR_W+1)'(cand_n) : '0;
        radd       = pop ? (ADDR_W+1)'(f_n[rd_ptr]) : '0;
        err_set    = (|(req_valid & ~owned & ~legal)) || (|(rel_valid & ~rel_ok));
        owned_next = owned;
        if (pop)
            owned_next[f_id[rd_ptr]] = 1'b0;
        if (grant)
            owned_next[cand] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            used      <= '0;
            rr        <= '0;
            owned     <= '0;
            f_done    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            gnt_base  <= '0;
            gnt_n     <= '0;
            rec_valid <= 1'b0;
            rec_base  <= '0;
            rec_n     <= '0;
            err       <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                f_id[i]    <= '0;
                f_n[i]     <= '0;
                slot_of[i] <= '0;
            end
        end else begin
            gnt_valid <= grant;
            rec_valid <= pop;
            owned     <= owned_next;
            used      <= used + gadd - radd;
            count     <= count + (IDW+1)'(grant) - (IDW+1)'(pop);
            err       <= err || err_set;
            for (int i = 0; i < NREQ; i++) begin
                if (rel_valid[i] && rel_ok[i])
                    f_done[slot_of[i]] <= 1'b1;
            end
            if (grant) begin
                gnt_id          <= cand;
                gnt_base        <= head;
                gnt_n           <= cand_n;
                head            <= head + ADDR_W'(cand_n);
                rr              <= cand + IDW'(1);
                f_id[wr_ptr]    <= cand;
                f_n[wr_ptr]     <= cand_n;
                f_done[wr_ptr]  <= 1'b0;
                slot_of[cand]   <= wr_ptr;
                wr_ptr          <= wr_ptr + IDW'(1);
            end
            if (pop) begin
                rec_base <= tail;
                rec_n    <= f_n[rd_ptr];
                tail     <= tail + ADDR_W'(f_n[rd_ptr]);
                rd_ptr   <= rd_ptr + IDW'(1);
            end
        end
    end

    assign used_slots = used;

endmodule

// File: tb/tb_spill_slot_scheduler.sv
// tb/tb_spill_slot_scheduler.sv - directed bench for spill_slot_scheduler
module tb_spill_slot_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  req_valid = '0;
    logic [63:0] req_n = '0;
    logic [7:0]  rel_valid = '0;
    logic        gnt_valid;
    logic [2:0]  gnt_id;
    logic [7:0]  gnt_base;
    logic [7:0]  gnt_n;
    logic [7:0]  owned;
    logic [8:0]  used_slots;
    logic        rec_valid;
    logic [7:0]  rec_base;
    logic [7:0]  rec_n;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    spill_slot_scheduler #(.NREQ(8), .SLOTS(256)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_n(req_n),
        .rel_valid(rel_valid), .gnt_valid(gnt_valid), .gnt_id(gnt_id),
        .gnt_base(gnt_base), .gnt_n(gnt_n), .owned(owned),
        .used_slots(used_slots), .rec_valid(rec_valid), .rec_base(rec_base),
        .rec_n(rec_n), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int n);
        req_valid[i] = 1'b1;
        req_n[8*i +: 8] = 8'(n);
    endtask

    task automatic clr_req(input int i);
        req_valid[i] = 1'b0;
    endtask

    task automatic pulse_rel(input int i);
        rel_valid[i] = 1'b1;
        tick();
        rel_valid[i] = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req_valid = '0;
        req_n = '0;
        rel_valid = '0;
        #2;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        logic [63:0] got;
        do_reset();
        got = {gnt_valid, gnt_id, gnt_base, gnt_n, owned, used_slots, rec_valid, rec_base, rec_n, err};
        if (got !== 64'd0) begin
            $display("FAIL reset_outputs got=%h exp=0", got);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_single;
        logic [31:0] got, exp;
        do_reset();
        set_req(0, 16);
        tick();
        clr_req(0);
        got = {gnt_valid, gnt_id, gnt_base, gnt_n, used_slots};
        exp = {1'b1, 3'd0, 8'd0, 8'd16, 9'd16};
        if (got !== exp) begin
            $display("FAIL single_grant got=%h exp=%h", got, exp);
            miscompares++;
        end
        vectors++;
        pulse_rel(0);
        if (rec_valid !== 1'b0) begin
            $display("FAIL single_rec_early got=%b exp=0", rec_valid);
            miscompares++;
        end
        vectors++;
        tick();
        got = {rec_valid, rec_base, rec_n, used_slots, owned[0]};
        exp = {1'b1, 8'd0, 8'd16, 9'd0, 1'b0};
        if (got !== exp) begin
            $display("FAIL single_reclaim got=%h exp=%h", got, exp);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_round_robin;
        logic [31:0] got, exp;
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 8);
        for (int k = 0; k < 4; k++) begin
            tick();
            got = {gnt_valid, gnt_id, gnt_base, gnt_n, used_slots};
            exp = {1'b1, 3'(k), 8'(8*k), 8'd8, 9'(8*(k+1))};
            if (got !== exp) begin
                $display("FAIL rr_grant%0d got=%h exp=%h", k, got, exp);
                miscompares++;
            end
            vectors++;
        end
        for (int i = 0; i < 4; i++) clr_req(i);
        tick();
        got = {gnt_valid, owned};
        exp = {1'b0, 8'h0f};
        if (got !== exp) begin
            $display("FAIL rr_idle got=%h exp=%h", got, exp);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_hol_fit_wrap;
        logic [31:0] got, exp;
        do_reset();
        set_req(5, 16);  tick(); clr_req(5);
        set_req(6, 200); tick(); clr_req(6);
        set_req(0, 34);  tick(); clr_req(0);
        got = {gnt_valid, gnt_id, gnt_base, gnt_n, used_slots};
        exp = {1'b1, 3'd0, 8'd216, 8'd34, 9'd250};
        if (got !== exp) begin
            $display("FAIL hol_fill got=%h exp=%h", got, exp);
            miscompares++;
        end
        vectors++;
        set_req(1, 10);
        set_req(2, 2);
        for (int k = 0; k < 2; k++) begin
            tick();
            got = {gnt_valid, used_slots};
            exp = {1'b0, 9'd250};
            if (got !== exp) begin
                $display("FAIL hol_block%0d got=%h exp=%h", k, got, exp);
                miscompares++;
            end
            vectors++;
        end
        pulse_rel(5);
        tick();
        got = {gnt_valid, rec_valid, rec_base, rec_n, used_slots};
        exp = {1'b0, 1'b1, 8'd0, 8'd16, 9'd234};
        if (got !== exp) begin
            $display("FAIL hol_reclaim got=%h exp=%h", got, exp);
            miscompares++;
        end
        vectors++;
        tick();
        clr_req(1);
        got = {gnt_valid, gnt_id, gnt_base, gnt_n, used_slots};
        exp = {1'b1, 3'd1, 8'd250, 8'd10, 9'd244};
        if (got !== exp) begin
            $display("FAIL wrap_grant got=%h exp=%h", got, exp);
            miscompares++;
        end
        vectors++;
        tick();
        clr_req(2);
        got = {gnt_valid, gnt_id, gnt_base, gnt_n, used_slots};
        exp = {1'b1, 3'd2, 8'd4, 8'd2, 9'd246};
        if (got !== exp) begin
            $display("FAIL wrap_head got=%h exp=%h", got, exp);
            miscompares++;
        end
        vectors++;
        if (owned !== 8'h47) begin
            $display("FAIL hol_owned got=%h exp=47", owned);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_out_of_order;
        logic [31:0] got, exp;
        do_reset();
        for (int i = 0; i < 3; i++) set_req(i, 4);
        tick(); tick(); tick();
        for (int i = 0; i < 3; i++) clr_req(i);
        got = {owned, used_slots};
        exp = {8'h07, 9'd12};
        if (got !== exp) begin
            $display("FAIL ooo_alloc got=%h exp=%h", got, exp);
            miscompares++;
        end
        vectors++;
        pulse_rel(2);
        tick();
        pulse_rel(1);
        tick();
        pulse_rel(0);
        if (rec_valid !== 1'b0) begin
            $display("FAIL ooo_wait got=%b exp=0", rec_valid);
            miscompares++;
        end
        vectors++;
        for (int k = 0; k < 3; k++) begin
            tick();
            got = {rec_valid, rec_base, rec_n, used_slots};
            exp = {1'b1, 8'(4*k), 8'd4, 9'(8 - 4*k)};
            if (got !== exp) begin
                $display("FAIL ooo_drain%0d got=%h exp=%h", k, got, exp);
                miscompares++;
            end
            vectors++;
        end
        tick();
        got = {rec_valid, owned, err};
        exp = {1'b0, 8'h00, 1'b0};
        if (got !== exp) begin
            $display("FAIL ooo_done got=%h exp=%h", got, exp);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_errors;
        logic [31:0] got, exp;
        do_reset();
        pulse_rel(3);
        got = {err, owned, used_slots, rec_valid, gnt_valid};
        exp = {1'b1, 8'h00, 9'd0, 1'b0, 1'b0};
        if (got !== exp) begin
            $display("FAIL err_nonowner got=%h exp=%h", got, exp);
            miscompares++;
        end
        vectors++;
        do_reset();
        if (err !== 1'b0) begin
            $display("FAIL err_cleared got=%b exp=0", err);
            miscompares++;
        end
        vectors++;
        set_req(4, 0);
        tick();
        clr_req(4);
        got = {err, gnt_valid, owned, used_slots};
        exp = {1'b1, 1'b0, 8'h00, 9'd0};
        if (got !== exp) begin
            $display("FAIL err_zero_n got=%h exp=%h", got, exp);
            miscompares++;
        end
        vectors++;
        do_reset();
        set_req(0, 5);
        tick();
        clr_req(0);
        rel_valid[0] = 1'b1;
        tick();
        got = {err, rec_valid};
        exp = {1'b0, 1'b0};
        if (got !== exp) begin
            $display("FAIL err_first_rel got=%h exp=%h", got, exp);
            miscompares++;
        end
        vectors++;
        tick();
        rel_valid[0] = 1'b0;
        got = {err, rec_valid, rec_n};
        exp = {1'b1, 1'b1, 8'd5};
        if (got !== exp) begin
            $display("FAIL err_double_rel got=%h exp=%h", got, exp);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_reset_mid;
        logic [63:0] got;
        logic [31:0] g, e;
        do_reset();
        set_req(0, 16);
        set_req(1, 16);
        tick();
        #2;
        rst = 1'b1;
        #1;
        got = {gnt_valid, gnt_id, gnt_base, gnt_n, owned, used_slots, rec_valid, rec_base, rec_n, err};
        if (got !== 64'd0) begin
            $display("FAIL reset_mid got=%h exp=0", got);
            miscompares++;
        end
        vectors++;
        tick();
        rst = 1'b0;
        tick();
        clr_req(0);
        g = {gnt_valid, gnt_id, gnt_base, gnt_n, used_slots};
        e = {1'b1, 3'd0, 8'd0, 8'd16, 9'd16};
        if (g !== e) begin
            $display("FAIL reset_rearb got=%h exp=%h", g, e);
            miscompares++;
        end
        vectors++;
        tick();
        clr_req(1);
        g = {gnt_valid, gnt_id, gnt_base, gnt_n, used_slots};
        e = {1'b1, 3'd1, 8'd16, 8'd16, 9'd32};
        if (g !== e) begin
            $display("FAIL reset_next got=%h exp=%h", g, e);
            miscompares++;
        end
        vectors++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_hol_fit_wrap();
        test_out_of_order();
        test_errors();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
